// File: rtl/com4_pkg.sv
// Shared types and constants for the com4 UART exchange host.
// COM4_HOST_CHECKSUM_EN adds a fifth XOR checksum byte in each direction.
package com4_pkg;

`ifdef COM4_HOST_CHECKSUM_EN
    localparam int FRAME_BYTES = 5;
`else
    localparam int FRAME_BYTES = 4;
`endif

    localparam int IDX_W = $clog2(FRAME_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        TX_BYTE,
        RX_WAIT,
        RX_BYTE,
        FINISH
    } state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/com4_host_rx.sv
// RX synchronizer and bit-period sampler for com4_host.
// Counting runs only while the host FSM holds run high.
module com4_host_rx
    import com4_pkg::*;
#(
    parameter int CPB = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       run,
    output logic       rx_s,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       stop_ok,
    output logic       start_glitch
);

    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);

    logic          rx_q1;
    logic          rx_q2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] target;
    logic [3:0]    bit_i;
    logic [7:0]    sh;
    logic          sample;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_q1 <= 1'b1;
            rx_q2 <= 1'b1;
        end else begin
            rx_q1 <= rx;
            rx_q2 <= rx_q1;
        end
    end

    assign rx_s = rx_q2;

    // Start bit is checked at half a period, later bits a full period apart.
    assign target = (bit_i == 4'd0) ? CW'(HALF - 1) : CW'(CPB - 1);
    assign sample = run && (cnt == target);

    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            cnt   <= '0;
            bit_i <= '0;
        end else if (sample) begin
            cnt   <= '0;
            bit_i <= bit_i + 4'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh <= '0;
        end else if (sample && bit_i >= 4'd1 && bit_i <= 4'd8) begin
            sh <= {rx_s, sh[7:1]};
        end
    end

    assign rx_byte      = sh;
    assign stop_ok      = rx_s;
    assign byte_valid   = sample && (bit_i == 4'd9);
    assign start_glitch = sample && (bit_i == 4'd0) && rx_s;

endmodule

// File: rtl/com4_host.sv
// Initiator for the com4 4-byte UART exchange: send a frame, collect the reply.
// Define COM4_HOST_CHECKSUM_EN for a fifth XOR byte and the ERR_CSUM output.
module com4_host
    import com4_pkg::*;
#(
    parameter int CLK_HZ      = 12000000,
    parameter int BAUD        = 9600,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RX,
    output logic       TX,
    input  logic       START,
    input  logic [7:0] TX_DATA0,
    input  logic [7:0] TX_DATA1,
    input  logic [7:0] TX_DATA2,
    input  logic [7:0] TX_DATA3,
    output logic [7:0] RX_DATA0,
    output logic [7:0] RX_DATA1,
    output logic [7:0] RX_DATA2,
    output logic [7:0] RX_DATA3,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR_TIMEOUT,
`ifdef COM4_HOST_CHECKSUM_EN
    output logic       ERR_CSUM,
`endif
    output logic       ERR_FRAME
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int CW  = $clog2(CPB);
    localparam int TW  = $clog2(TIMEOUT_CYC);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_BYTES - 1);

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx;
    logic [CW-1:0]    tx_cnt;
    logic [3:0]       tx_bit;
    logic [9:0]       tx_sh;
    logic [7:0]       tx_buf [FRAME_BYTES];
    logic [7:0]       rx_mem [FRAME_BYTES];
    logic [TW-1:0]    to_cnt;
    logic             err_to;
    logic             err_fr;

    logic             accept;
    logic             tx_bit_end;
    logic             tx_byte_end;
    logic             timeout;

    logic             rx_s;
    logic             byte_valid;
    logic [7:0]       rx_byte;
    logic             stop_ok;
    logic             start_glitch;

    com4_host_rx #(
        .CPB (CPB)
    ) u_rx (
        .clk          (CLK),
        .rst_n        (RST_N),
        .rx           (RX),
        .run          (state == RX_BYTE),
        .rx_s         (rx_s),
        .byte_valid   (byte_valid),
        .rx_byte      (rx_byte),
        .stop_ok      (stop_ok),
        .start_glitch (start_glitch)
    );

    assign accept      = (state == IDLE) && START;
    assign tx_bit_end  = (state == TX_BYTE) && (tx_cnt == CW'(CPB - 1));
    assign tx_byte_end = tx_bit_end && (tx_bit == 4'd9);
    assign timeout     = (state == RX_WAIT) && (to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (START) state_nx = TX_BYTE;
            end
            TX_BYTE: begin
                if (tx_byte_end && idx == LAST) state_nx = RX_WAIT;
            end
            RX_WAIT: begin
                if (!rx_s) state_nx = RX_BYTE;
                else if (timeout) state_nx = FINISH;
            end
            RX_BYTE: begin
                unique case (1'b1)
                    start_glitch: state_nx = RX_WAIT;
                    byte_valid: begin
                        if (!stop_ok || idx == LAST) state_nx = FINISH;
                        else state_nx = RX_WAIT;
                    end
                    default: ;
                endcase
            end
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        TX   = 1'b1;
        BUSY = 1'b0;
        DONE = 1'b0;
        unique case (state)
            TX_BYTE: begin
                TX   = tx_sh[0];
                BUSY = 1'b1;
            end
            RX_WAIT, RX_BYTE: BUSY = 1'b1;
            FINISH: DONE = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            idx    <= '0;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '1;
            to_cnt <= '0;
            err_to <= 1'b0;
            err_fr <= 1'b0;
            for (int i = 0; i < FRAME_BYTES; i++) begin
                tx_buf[i] <= '0;
                rx_mem[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        tx_buf[0] <= TX_DATA0;
                        tx_buf[1] <= TX_DATA1;
                        tx_buf[2] <= TX_DATA2;
                        tx_buf[3] <= TX_DATA3;
`ifdef COM4_HOST_CHECKSUM_EN
                        tx_buf[4] <= TX_DATA0 ^ TX_DATA1
                                   ^ TX_DATA2 ^ TX_DATA3;
`endif
                        tx_sh  <= {1'b1, TX_DATA0, 1'b0};
                        idx    <= '0;
                        tx_cnt <= '0;
                        tx_bit <= '0;
                        err_to <= 1'b0;
                        err_fr <= 1'b0;
                    end
                end
                TX_BYTE: begin
                    if (!tx_bit_end) begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end else begin
                        tx_cnt <= '0;
                        if (tx_bit != 4'd9) begin
                            tx_bit <= tx_bit + 4'd1;
                            tx_sh  <= {1'b1, tx_sh[9:1]};
                        end else if (idx == LAST) begin
                            tx_bit <= '0;
                            idx    <= '0;
                            to_cnt <= '0;
                        end else begin
                            // Next byte follows the stop bit with no gap.
                            tx_bit <= '0;
                            idx    <= idx + IDX_W'(1);
                            tx_sh  <= {1'b1, tx_buf[idx + IDX_W'(1)], 1'b0};
                        end
                    end
                end
                RX_WAIT: begin
                    if (rx_s) begin
                        if (timeout) err_to <= 1'b1;
                        else to_cnt <= to_cnt + TW'(1);
                    end
                end
                RX_BYTE: begin
                    if (byte_valid) begin
                        rx_mem[idx] <= rx_byte;
                        if (!stop_ok) begin
                            err_fr <= 1'b1;
                        end else if (idx != LAST) begin
                            idx    <= idx + IDX_W'(1);
                            to_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef COM4_HOST_CHECKSUM_EN
    logic       err_cs;
    logic [7:0] rx_xor;

    assign rx_xor = rx_mem[0] ^ rx_mem[1] ^ rx_mem[2] ^ rx_mem[3];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            err_cs <= 1'b0;
        end else if (accept) begin
            err_cs <= 1'b0;
        end else if (state == RX_BYTE && byte_valid
                     && stop_ok && idx == LAST) begin
            err_cs <= (rx_byte != rx_xor);
        end
    end

    assign ERR_CSUM = err_cs;
`endif

    assign RX_DATA0    = rx_mem[0];
    assign RX_DATA1    = rx_mem[1];
    assign RX_DATA2    = rx_mem[2];
    assign RX_DATA3    = rx_mem[3];
    assign ERR_TIMEOUT = err_to;
    assign ERR_FRAME   = err_fr;

endmodule

// File: tb/tb_com4_host.sv
// Scoreboard bench for com4_host: directed exchanges, UART decode of TX.
// Define COM4_HOST_CHECKSUM_EN to exercise the five-byte build.
module tb_com4_host;

`ifdef COM4_HOST_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int CPB = 10;
    localparam int TO  = 500;
    localparam int TXC = NB * 10 * CPB;

    typedef struct packed {
        logic [3:0][7:0] d;
        logic            to;
        logic            fr;
        logic            cs;
        logic [31:0]     at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       start;
    logic [7:0] td0, td1, td2, td3;
    logic       tx;
    logic [7:0] rd0, rd1, rd2, rd3;
    logic       busy;
    logic       done;
    logic       err_to;
    logic       err_fr;
`ifdef COM4_HOST_CHECKSUM_EN
    logic       err_cs;
`endif

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         accept_cyc = 0;
    bit         tx_check_en = 1'b1;
    exp_t       expq[$];
    logic [7:0] txq[$];
    exp_t       me;
    exp_t       ne;
    logic [3:0][7:0] r;

    com4_host #(
        .CLK_HZ      (1000000),
        .BAUD        (100000),
        .TIMEOUT_CYC (TO)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .RX          (rx),
        .TX          (tx),
        .START       (start),
        .TX_DATA0    (td0),
        .TX_DATA1    (td1),
        .TX_DATA2    (td2),
        .TX_DATA3    (td3),
        .RX_DATA0    (rd0),
        .RX_DATA1    (rd1),
        .RX_DATA2    (rd2),
        .RX_DATA3    (rd3),
        .BUSY        (busy),
        .DONE        (done),
        .ERR_TIMEOUT (err_to),
`ifdef COM4_HOST_CHECKSUM_EN
        .ERR_CSUM    (err_cs),
`endif
        .ERR_FRAME   (err_fr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [3:0][7:0] mk(input logic [7:0] a, b, c, e);
        return {e, c, b, a};
    endfunction

    function automatic logic [7:0] x4(input logic [3:0][7:0] d);
        return d[0] ^ d[1] ^ d[2] ^ d[3];
    endfunction

    function automatic exp_t mkexp(input logic [3:0][7:0] d, input logic t,
                                   input logic f, input logic c);
        exp_t e;
        e.d  = d;
        e.to = t;
        e.fr = f;
        e.cs = c;
        e.at = '0;
        return e;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic [3:0][7:0] d, input bit expect_tx);
        if (expect_tx) begin
            for (int i = 0; i < 4; i++) txq.push_back(d[i]);
            if (NB == 5) txq.push_back(x4(d));
        end
        @(negedge clk);
        start = 1'b1;
        td0 = d[0];
        td1 = d[1];
        td2 = d[2];
        td3 = d[3];
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        td0 = '0;
        td1 = '0;
        td2 = '0;
        td3 = '0;
        accept_cyc = cyc;
        chk("tx_start_bit", tx, 0);
        chk("busy_set", busy, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stp);
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(CPB);
        end
        rx = stp;
        cycles(CPB);
        rx = 1'b1;
        cycles(2);
    endtask

    task automatic reply(input logic [3:0][7:0] d, input int bad,
                         input logic [7:0] cs);
        for (int i = 0; i < 4; i++) begin
            send_byte(d[i], logic'(i != bad));
            if (i == bad) return;
        end
        if (NB == 5) send_byte(cs, 1'b1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", expq.size(), 0);
        cycles(3);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got DONE=1, expected no DONE");
            end else begin
                me = expq.pop_front();
                chk("rx_data0", rd0, me.d[0]);
                chk("rx_data1", rd1, me.d[1]);
                chk("rx_data2", rd2, me.d[2]);
                chk("rx_data3", rd3, me.d[3]);
                chk("err_timeout", err_to, me.to);
                chk("err_frame", err_fr, me.fr);
                chk("busy_clear", busy, 0);
`ifdef COM4_HOST_CHECKSUM_EN
                chk("err_csum", err_cs, me.cs);
`endif
                if (me.at != 0) chk("done_cycle", cyc, me.at);
            end
        end
    end

    initial begin : tx_mon
        logic [7:0] b;
        logic       stp;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                repeat (CPB / 2 - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                stp = tx;
                if (tx_check_en) begin
                    if (txq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_extra_byte: got %0h, expected none", b);
                    end else begin
                        chk("tx_byte", b, txq.pop_front());
                        chk("tx_stop", stp, 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish by 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        start = 1'b0;
        td0   = '0;
        td1   = '0;
        td2   = '0;
        td3   = '0;
        cycles(5);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_to", err_to, 0);
        chk("rst_err_fr", err_fr, 0);
        chk("rst_rd0", rd0, 0);
        rst_n = 1'b1;
        cycles(5);

        // Normal exchange
        r = mk(8'h12, 8'h34, 8'h56, 8'h78);
        expq.push_back(mkexp(r, 1'b0, 1'b0, 1'b0));
        do_start(mk(8'h55, 8'hA3, 8'h00, 8'hFF), 1'b1);
        cycles(TXC - 1);
        chk("tx_sent_in_time", txq.size(), 0);
        chk("tx_last_stop", tx, 1);
        chk("busy_end_tx", busy, 1);
        cycles(6);
        reply(r, -1, x4(r));
        wait_done();

        // No reply: timeout
        do_start(mk(8'h11, 8'h22, 8'h33, 8'h44), 1'b1);
        ne = mkexp(r, 1'b1, 1'b0, 1'b0);
        ne.at = 32'(accept_cyc + TXC + TO);
        expq.push_back(ne);
        wait_done();
        chk("err_timeout_held", err_to, 1);

        // Framing error on byte 2
        expq.push_back(mkexp(mk(8'h9A, 8'hBC, 8'hDE, 8'h78), 1'b0, 1'b1, 1'b0));
        do_start(mk(8'hA0, 8'hB1, 8'hC2, 8'hD3), 1'b1);
        chk("err_timeout_cleared", err_to, 0);
        cycles(TXC + 5);
        reply(mk(8'h9A, 8'hBC, 8'hDE, 8'h00), 2, 8'h00);
        wait_done();
        chk("err_frame_held", err_fr, 1);

        // Reset in the middle of a send
        tx_check_en = 1'b0;
        do_start(mk(8'hC3, 8'hC3, 8'hC3, 8'hC3), 1'b0);
        cycles(50);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd0", rd0, 0);
        chk("mid_rst_rd1", rd1, 0);
        chk("mid_rst_rd2", rd2, 0);
        chk("mid_rst_rd3", rd3, 0);
        chk("mid_rst_err_fr", err_fr, 0);
        cycles(2);
        rst_n = 1'b1;
        cycles(120);
        tx_check_en = 1'b1;

        // RX glitch in RX_WAIT, START ignored while busy
        r = mk(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        expq.push_back(mkexp(r, 1'b0, 1'b0, 1'b0));
        do_start(mk(8'h3C, 8'h5A, 8'h69, 8'h96), 1'b1);
        cycles(120);
        start = 1'b1;
        td0 = 8'hFF;
        td1 = 8'hFF;
        td2 = 8'hFF;
        td3 = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_mid_send", busy, 1);
        cycles(TXC + 20 - 121);
        rx = 1'b0;
        cycles(3);
        rx = 1'b1;
        cycles(30);
        chk("busy_after_glitch", busy, 1);
        reply(r, -1, x4(r));
        wait_done();

`ifdef COM4_HOST_CHECKSUM_EN
        // Checksum mismatch on the reply
        expq.push_back(mkexp(mk(8'h01, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0, 1'b1));
        do_start(mk(8'h01, 8'h02, 8'h04, 8'h08), 1'b1);
        cycles(TXC + 5);
        reply(mk(8'h01, 8'h00, 8'h00, 8'h00), -1, 8'h00);
        wait_done();
`endif

        cycles(20);
        chk("expq_empty", expq.size(), 0);
        chk("txq_empty", txq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
